// File: rtl/output_port_tx.sv
// ---------------------------------------------------------------------------
// output_port_tx
//
// Serial transmitter for the CPU output port. Every word the CPU writes to its
// output register is queued in a small FIFO. Each word is then sent over an
// 8N1 UART-style line, least-significant byte first and LSB first within each
// byte. Consecutive words are separated by one idle-high cycle (the LOAD
// cycle). The bytes of one word follow each other with no gap.
//
// Parameters:
//   DATA_WIDTH    width of an output word (multiple of 8)
//   FIFO_DEPTH    number of buffered words (power of two, >= 2)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_ni    asynchronous active-low reset
//   out_ld_i    write strobe from the CPU; one word accepted per high cycle
//   out_i       word from the CPU, sampled when out_ld_i is high
//   tx_o        registered serial line, idles high
//   busy_o      FIFO non-empty or transmitter not idle
//   empty_o     FIFO holds no words
//   full_o      FIFO holds FIFO_DEPTH words
//   overflow_o  sticky: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module output_port_tx #(
   parameter int DATA_WIDTH   = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  out_ld_i,
   input  logic [DATA_WIDTH-1:0] out_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overflow_o
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CLK_W  = $clog2(CLKS_PER_BIT);
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                state;
   logic                  tx;
   logic [CLK_W-1:0]      clk_cnt;
   logic [2:0]            bit_cnt;
   logic [BIDX_W-1:0]     byte_idx;
   logic [DATA_WIDTH-1:0] shreg;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  overflow;

   logic full;
   logic empty;
   logic pop;
   logic push;
   logic drop;
   logic bit_end;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   // The head word leaves the FIFO on the LOAD->START edge, so a write that
   // lands on that same edge still fits even when the FIFO is full.
   assign pop     = (state == S_LOAD);
   assign push    = out_ld_i && (!full || pop);
   assign drop    = out_ld_i && full && !pop;
   assign bit_end = (clk_cnt == CLK_LAST);

   // ---- FIFO storage (data only, no reset) ----
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= out_i;
      end
   end

   // ---- FIFO control ----
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // ---- Shift register (data only, no reset) ----
   // The whole word shifts right one bit per data bit; since both byte order
   // and bit order are LSB first, the next bit to send is always shreg[0].
   always_ff @(posedge clk_i) begin
      if (state == S_LOAD) begin
         shreg <= mem[rd_ptr];
      end else if (bit_end && ((state == S_START) ||
                               ((state == S_DATA) && (bit_cnt != 3'd7)))) begin
         shreg <= shreg >> 1;
      end
   end

   // ---- Transmit state machine with registered line output ----
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tx      <= 1'b1;
               clk_cnt <= '0;
               if (!empty) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx       <= 1'b0;
               clk_cnt  <= '0;
               byte_idx <= '0;
               state    <= S_START;
            end
            S_START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
                  state   <= S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CLK_W'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[0];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CLK_W'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (byte_idx != BYTE_LAST) begin
                     // Next byte of the same word starts with no gap.
                     byte_idx <= byte_idx + BIDX_W'(1);
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else if (!empty) begin
                     tx    <= 1'b1;
                     state <= S_LOAD;
                  end else begin
                     tx    <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CLK_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_o       = tx;
   assign busy_o     = !empty || (state != S_IDLE);
   assign empty_o    = empty;
   assign full_o     = full;
   assign overflow_o = overflow;

endmodule

// File: tb/tb_output_port_tx.sv
// ---------------------------------------------------------------------------
// tb_output_port_tx
//
// Bench for output_port_tx with DATA_WIDTH=16, FIFO_DEPTH=4, CLKS_PER_BIT=4.
// A reference model keeps the FIFO as a queue of words and the line as a
// queue of per-cycle levels built from the 8N1 frame rule; a line decoder
// recovers words from tx_o and compares them with the accepted words.
// ---------------------------------------------------------------------------
module tb_output_port_tx;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int BYTES = DW / 8;

   logic          clk = 1'b0;
   logic          reset_ni = 1'b0;
   logic          out_ld = 1'b0;
   logic [DW-1:0] out_w = '0;
   logic          tx_o, busy_o, empty_o, full_o, overflow_o;

   output_port_tx #(
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (DEPTH),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk_i     (clk),
      .reset_ni  (reset_ni),
      .out_ld_i  (out_ld),
      .out_i     (out_w),
      .tx_o      (tx_o),
      .busy_o    (busy_o),
      .empty_o   (empty_o),
      .full_o    (full_o),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] accq[$];
   logic [DW-1:0] rxq[$];
   bit            line[$];
   bit            load_pending;
   bit            m_idle;
   bit            m_ovf;
   bit            m_tx;

   // line decoder state
   bit            dec_act;
   int            dec_cnt;
   int            dec_nb;
   logic [7:0]    dec_byte;
   logic [DW-1:0] dec_word;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      accq.delete();
      rxq.delete();
      line.delete();
      load_pending = 0;
      m_idle       = 1;
      m_ovf        = 0;
      m_tx         = 1;
      dec_act      = 0;
      dec_cnt      = 0;
      dec_nb       = 0;
      dec_byte     = '0;
      dec_word     = '0;
   endtask

   // A word on the line: per byte, start low, 8 data bits LSB first, stop high.
   task automatic build_frame(input logic [DW-1:0] w);
      logic [7:0] b;
      for (int k = 0; k < BYTES; k++) begin
         b = w[8*k +: 8];
         for (int c = 0; c < CPB; c++) line.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) line.push_back(b[i]);
         for (int c = 0; c < CPB; c++) line.push_back(1'b1);
      end
   endtask

   // One rising edge of the model, using the inputs as they were before it.
   task automatic model_step();
      bit pop = 0;
      int pre = mq.size();
      if (load_pending) begin
         build_frame(mq.pop_front());
         pop          = 1;
         load_pending = 0;
         m_idle       = 0;
         m_tx         = line.pop_front();
      end else if (line.size() > 0) begin
         m_tx = line.pop_front();
      end else if (pre > 0) begin
         load_pending = 1;
         m_idle       = 0;
         m_tx         = 1;
      end else begin
         m_idle = 1;
         m_tx   = 1;
      end
      if (out_ld) begin
         if (pre < DEPTH || pop) begin
            mq.push_back(out_w);
            accq.push_back(out_w);
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic check_outs();
      chk("tx", tx_o, m_tx);
      chk("busy", busy_o, (mq.size() != 0) || !m_idle);
      chk("empty", empty_o, mq.size() == 0);
      chk("full", full_o, mq.size() == DEPTH);
      chk("overflow", overflow_o, m_ovf);
   endtask

   task automatic decode();
      if (!dec_act) begin
         if (tx_o == 1'b0) begin
            dec_act = 1;
            dec_cnt = 0;
         end
      end else begin
         dec_cnt++;
         for (int i = 0; i < 8; i++)
            if (dec_cnt == CPB*(1+i) + CPB/2) dec_byte[i] = tx_o;
         if (dec_cnt == CPB*9 + CPB/2) begin
            chk("stop_bit", tx_o, 1);
            dec_word[8*dec_nb +: 8] = dec_byte;
            dec_nb++;
            if (dec_nb == BYTES) begin
               rxq.push_back(dec_word);
               dec_nb = 0;
            end
            dec_act = 0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset_ni) model_reset();
      else model_step();
      #1;
      check_outs();
      decode();
   endtask

   task automatic push(input logic [DW-1:0] w);
      out_ld = 1'b1;
      out_w  = w;
      cycle();
      out_ld = 1'b0;
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      model_reset();
      #1;
      check_outs();
      cycle();
      cycle();
      reset_ni = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy_o === 1'b1 || !m_idle || mq.size() > 0) && n < 3000) begin
         cycle();
         n++;
      end
      chk("drain_bound", n < 3000, 1);
      repeat (3) cycle();
   endtask

   task automatic check_rx(input string tag);
      int n;
      chk({tag, "_count"}, rxq.size(), accq.size());
      n = (rxq.size() < accq.size()) ? rxq.size() : accq.size();
      for (int i = 0; i < n; i++) chk({tag, "_word"}, rxq[i], accq[i]);
   endtask

   task automatic clear_logs();
      accq.delete();
      rxq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sent;
      logic [DW-1:0] w;

      // 1: reset, then idle
      model_reset();
      cycle();
      cycle();
      reset_ni = 1'b1;
      repeat (20) cycle();
      chk("s1_tx", tx_o, 1);
      chk("s1_busy", busy_o, 0);

      // 2: single word, start bit two edges after the push
      clear_logs();
      push(16'h41A5);
      chk("s2_empty_after_push", empty_o, 0);
      cycle();
      chk("s2_tx_load", tx_o, 1);
      cycle();
      chk("s2_tx_start", tx_o, 0);
      drain();
      check_rx("s2_rx");
      if (rxq.size() > 0) chk("s2_word", rxq[0], 16'h41A5);

      // 3: overflow on the sixth back-to-back push
      clear_logs();
      for (int i = 1; i <= 6; i++) begin
         push(DW'(i));
         if (i == 5) chk("s3_full", full_o, 1);
      end
      chk("s3_ovf", overflow_o, 1);
      drain();
      chk("s3_rx_count", rxq.size(), 5);
      for (int i = 0; i < 5 && i < rxq.size(); i++) chk("s3_rx_word", rxq[i], i + 1);
      chk("s3_ovf_sticky", overflow_o, 1);

      // 4: push on the LOAD->START edge while full
      do_reset();
      clear_logs();
      for (int i = 0; i < 5; i++) push(16'h1000 + DW'(i));
      chk("s4_full", full_o, 1);
      n = 0;
      while (!load_pending && n < 500) begin
         cycle();
         n++;
      end
      chk("s4_wait_load", n < 500, 1);
      push(16'hBEEF);
      chk("s4_full_after", full_o, 1);
      chk("s4_ovf", overflow_o, 0);
      drain();
      check_rx("s4_rx");

      // 5: stream 10 words honouring full_o
      clear_logs();
      sent = 0;
      n = 0;
      while (sent < 10 && n < 5000) begin
         if (!full_o && $urandom_range(0, 1) == 1) begin
            push(DW'($urandom));
            sent++;
         end else begin
            cycle();
         end
         n++;
      end
      drain();
      chk("s5_rx_count", rxq.size(), 10);
      check_rx("s5_rx");
      chk("s5_ovf", overflow_o, 0);
      chk("s5_empty", empty_o, 1);

      // 6: reset in the middle of byte 1 data bits
      clear_logs();
      w = DW'($urandom);
      push(w);
      n = 0;
      while (line.size() != 29 && n < 500) begin
         cycle();
         n++;
      end
      chk("s6_wait_data", n < 500, 1);
      reset_ni = 1'b0;
      model_reset();
      #1;
      chk("s6_tx_now", tx_o, 1);
      chk("s6_empty_now", empty_o, 1);
      check_outs();
      cycle();
      cycle();
      reset_ni = 1'b1;
      cycle();
      push(16'h00FF);
      drain();
      chk("s6_rx_count", rxq.size(), 1);
      if (rxq.size() > 0) chk("s6_word", rxq[0], 16'h00FF);

      // random traffic, overflow allowed
      do_reset();
      clear_logs();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            for (int j = $urandom_range(1, 3); j > 0; j--) push(DW'($urandom));
         end else begin
            cycle();
         end
      end
      drain();
      check_rx("rnd_rx");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
